// File: rtl/vc_to_d_arbiter.sv
// Forwards one word per cycle from the VC0/VC1 FIFO heads to the D0/D1 FIFOs by fixed priority.
// The pop is combinational; the push is registered one cycle later and counted per destination.
module vc_to_d_arbiter #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic                 vc0_empty,
    output logic                 vc0_pop,
    input  logic [DATA_SIZE-1:0] vc1_data,
    input  logic                 vc1_empty,
    output logic                 vc1_pop,
    input  logic                 d0_pause,
    input  logic                 d1_pause,
    output logic [DATA_SIZE-1:0] d_data,
    output logic                 d0_push,
    output logic                 d1_push,
    output logic [CNT_SIZE-1:0]  fwd_cnt0,
    output logic [CNT_SIZE-1:0]  fwd_cnt1,
    output logic                 idle
);

    logic                 vc0_paused;
    logic                 vc1_paused;
    logic                 vc0_elig;
    logic                 vc1_elig;
    logic                 pop_any;
    logic [DATA_SIZE-1:0] pop_word;

    logic [DATA_SIZE-1:0] d_data_q, d_data_d;
    logic                 d0_push_q, d0_push_d;
    logic                 d1_push_q, d1_push_d;
    logic [CNT_SIZE-1:0]  cnt0_q, cnt0_d;
    logic [CNT_SIZE-1:0]  cnt1_q, cnt1_d;

    // Each head checks only its own destination's pause, so a stalled VC0 never blocks VC1.
    assign vc0_paused = vc0_data[DEST_BIT] ? d1_pause : d0_pause;
    assign vc1_paused = vc1_data[DEST_BIT] ? d1_pause : d0_pause;

    assign vc0_elig = reset_L & enable & ~vc0_empty & ~vc0_paused;
    assign vc1_elig = reset_L & enable & ~vc1_empty & ~vc1_paused;

    assign vc0_pop  = vc0_elig;
    assign vc1_pop  = ~vc0_elig & vc1_elig;
    assign pop_any  = vc0_pop | vc1_pop;
    assign pop_word = vc0_elig ? vc0_data : vc1_data;

    always_comb begin
        d_data_d  = d_data_q;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        if (pop_any) begin
            d_data_d  = pop_word;
            d0_push_d = ~pop_word[DEST_BIT];
            d1_push_d = pop_word[DEST_BIT];
        end
        cnt0_d = cnt0_q + {{(CNT_SIZE-1){1'b0}}, d0_push_q};
        cnt1_d = cnt1_q + {{(CNT_SIZE-1){1'b0}}, d1_push_q};
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d_data_q  <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            d_data_q  <= d_data_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign d_data   = d_data_q;
    assign d0_push  = d0_push_q;
    assign d1_push  = d1_push_q;
    assign fwd_cnt0 = cnt0_q;
    assign fwd_cnt1 = cnt1_q;
    assign idle     = vc0_empty & vc1_empty & ~d0_push_q & ~d1_push_q;

endmodule

// File: tb/tb_vc_to_d_arbiter.sv
// Bench for vc_to_d_arbiter: queue-based VC FIFOs, a transaction-level model checked every
// negedge, and directed scenarios with hand-computed literal expectations.
module tb_vc_to_d_arbiter;

    logic       clk;
    logic       reset_L;
    logic       enable;
    logic [5:0] vc0_data, vc1_data;
    logic       vc0_empty, vc1_empty;
    logic       vc0_pop, vc1_pop;
    logic       d0_pause, d1_pause;
    logic [5:0] d_data;
    logic       d0_push, d1_push;
    logic [7:0] fwd_cnt0, fwd_cnt1;
    logic       idle;

    int tests = 0;
    int fails = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    // Model of what the output register and counters must hold
    logic [5:0] m_data = '0;
    bit         m_p0 = 0;
    bit         m_p1 = 0;
    int         m_c0 = 0;
    int         m_c1 = 0;

    vc_to_d_arbiter dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .vc0_data(vc0_data), .vc0_empty(vc0_empty), .vc0_pop(vc0_pop),
        .vc1_data(vc1_data), .vc1_empty(vc1_empty), .vc1_pop(vc1_pop),
        .d0_pause(d0_pause), .d1_pause(d1_pause),
        .d_data(d_data), .d0_push(d0_push), .d1_push(d1_push),
        .fwd_cnt0(fwd_cnt0), .fwd_cnt1(fwd_cnt1), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which VC the rules select this cycle: -1 none, else the VC index (lower index wins).
    function automatic int pick();
        logic [5:0] head [2];
        bit         emp  [2];
        head[0] = vc0_data; head[1] = vc1_data;
        emp[0]  = vc0_empty; emp[1] = vc1_empty;
        if (!reset_L || !enable) return -1;
        for (int v = 0; v < 2; v++) begin
            if (!emp[v] && !(head[v][4] ? d1_pause : d0_pause)) return v;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_data = '0; m_p0 = 0; m_p1 = 0; m_c0 = 0; m_c1 = 0;
        end else begin
            int sel;
            logic [5:0] w;
            if (m_p0) m_c0 = (m_c0 + 1) % 256;
            if (m_p1) m_c1 = (m_c1 + 1) % 256;
            sel = pick();
            if (sel >= 0) begin
                w = (sel == 0) ? vc0_data : vc1_data;
                m_data = w;
                m_p0 = (w[4] == 1'b0);
                m_p1 = (w[4] == 1'b1);
            end else begin
                m_p0 = 0; m_p1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        int sel;
        sel = pick();
        chk("model_vc0_pop", 32'(vc0_pop), 32'(sel == 0));
        chk("model_vc1_pop", 32'(vc1_pop), 32'(sel == 1));
        chk("model_d_data", 32'(d_data), 32'(m_data));
        chk("model_d0_push", 32'(d0_push), 32'(m_p0));
        chk("model_d1_push", 32'(d1_push), 32'(m_p1));
        chk("model_fwd_cnt0", 32'(fwd_cnt0), 32'(m_c0));
        chk("model_fwd_cnt1", 32'(fwd_cnt1), 32'(m_c1));
        chk("model_idle", 32'(idle), 32'(vc0_empty & vc1_empty & !m_p0 & !m_p1));
    end

    task automatic drive();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = (q0.size() > 0) ? q0[0] : 6'h00;
        vc1_data  = (q1.size() > 0) ? q1[0] : 6'h00;
    endtask

    // Advance one cycle, acting as the VC FIFOs: a head leaves when it was popped.
    task automatic tick();
        logic p0, p1;
        logic [5:0] tmp;
        @(negedge clk);
        p0 = vc0_pop;
        p1 = vc1_pop;
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) tmp = q0.pop_front();
        if (p1 && q1.size() > 0) tmp = q1.pop_front();
        drive();
    endtask

    initial begin
        reset_L = 1'b0; enable = 1'b0; d0_pause = 1'b0; d1_pause = 1'b0;
        drive();
        #1;
        chk("rst_d_data", 32'(d_data), 32'h0);
        chk("rst_d0_push", 32'(d0_push), 32'h0);
        chk("rst_vc0_pop", 32'(vc0_pop), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        repeat (3) tick();
        reset_L = 1'b1;
        #1;
        chk("post_rst_idle", 32'(idle), 32'h1);

        // Single VC0 word to D0
        enable = 1'b1;
        q0.push_back(6'h0F); drive();
        #1;
        chk("single_vc0_pop", 32'(vc0_pop), 32'h1);
        chk("single_vc1_pop", 32'(vc1_pop), 32'h0);
        chk("single_idle_busy", 32'(idle), 32'h0);
        tick(); #1;
        chk("single_d_data", 32'(d_data), 32'h0F);
        chk("single_d0_push", 32'(d0_push), 32'h1);
        chk("single_d1_push", 32'(d1_push), 32'h0);
        tick(); #1;
        chk("single_cnt0", 32'(fwd_cnt0), 32'h1);
        chk("single_idle_back", 32'(idle), 32'h1);

        // Both heads valid, VC0 first
        q0.push_back(6'h12); q1.push_back(6'h03); drive();
        #1;
        chk("both_vc0_pop", 32'(vc0_pop), 32'h1);
        chk("both_vc1_wait", 32'(vc1_pop), 32'h0);
        tick(); #1;
        chk("both_d_data_12", 32'(d_data), 32'h12);
        chk("both_d1_push", 32'(d1_push), 32'h1);
        chk("both_vc1_pop", 32'(vc1_pop), 32'h1);
        tick(); #1;
        chk("both_d_data_03", 32'(d_data), 32'h03);
        chk("both_d0_push", 32'(d0_push), 32'h1);
        tick(); #1;
        chk("both_cnt0", 32'(fwd_cnt0), 32'h2);
        chk("both_cnt1", 32'(fwd_cnt1), 32'h1);
        chk("both_idle", 32'(idle), 32'h1);

        // Head-of-line avoidance
        d1_pause = 1'b1;
        q0.push_back(6'h10); q1.push_back(6'h05); drive();
        #1;
        chk("hol_vc0_blocked", 32'(vc0_pop), 32'h0);
        chk("hol_vc1_pop", 32'(vc1_pop), 32'h1);
        tick(); #1;
        chk("hol_d_data_05", 32'(d_data), 32'h05);
        chk("hol_d0_push", 32'(d0_push), 32'h1);
        chk("hol_vc0_still", 32'(vc0_pop), 32'h0);
        tick(); tick(); #1;
        chk("hol_vc0_held", 32'(vc0_pop), 32'h0);
        chk("hol_hold_d_data", 32'(d_data), 32'h05);
        d1_pause = 1'b0;
        #1;
        chk("hol_vc0_release", 32'(vc0_pop), 32'h1);
        tick(); #1;
        chk("hol_d_data_10", 32'(d_data), 32'h10);
        chk("hol_d1_push", 32'(d1_push), 32'h1);
        tick();

        // Enable gating
        enable = 1'b0;
        q0.push_back(6'h01); q1.push_back(6'h11); drive();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("gate_vc0_pop", 32'(vc0_pop), 32'h0);
            chk("gate_vc1_pop", 32'(vc1_pop), 32'h0);
            chk("gate_idle", 32'(idle), 32'h0);
            tick();
        end
        enable = 1'b1;
        #1;
        chk("gate_resume", 32'(vc0_pop), 32'h1);
        tick(); #1;
        chk("gate_d_data_01", 32'(d_data), 32'h01);
        chk("gate_vc1_next", 32'(vc1_pop), 32'h1);
        tick(); #1;
        chk("gate_d_data_11", 32'(d_data), 32'h11);
        chk("gate_d1_push", 32'(d1_push), 32'h1);
        tick(); #1;
        chk("gate_cnt0", 32'(fwd_cnt0), 32'h4);
        chk("gate_cnt1", 32'(fwd_cnt1), 32'h3);

        // Asynchronous reset with a push in flight
        q0.push_back(6'h0A); q0.push_back(6'h0B); drive();
        tick(); #1;
        chk("arst_pre_push", 32'(d0_push), 32'h1);
        chk("arst_pre_data", 32'(d_data), 32'h0A);
        #1;
        reset_L = 1'b0;
        #1;
        chk("arst_d0_push", 32'(d0_push), 32'h0);
        chk("arst_d_data", 32'(d_data), 32'h0);
        chk("arst_cnt0", 32'(fwd_cnt0), 32'h0);
        chk("arst_cnt1", 32'(fwd_cnt1), 32'h0);
        chk("arst_vc0_pop", 32'(vc0_pop), 32'h0);
        tick(); tick();
        reset_L = 1'b1;
        #1;
        chk("arst_first_pop", 32'(vc0_pop), 32'h1);
        tick(); #1;
        chk("arst_d_data_0b", 32'(d_data), 32'h0B);
        chk("arst_push_0b", 32'(d0_push), 32'h1);
        tick();

        // Counter wrap: 256 back-to-back D0 words; fwd_cnt0 is 1 going in
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            q0.push_back({kb[5], 1'b0, kb[3:0]});
        end
        drive();
        for (int k = 1; k <= 256; k++) begin
            tick(); #1;
            chk("wrap_d0_push", 32'(d0_push), 32'h1);
            if (k == 255) chk("wrap_cnt_255", 32'(fwd_cnt0), 32'd255);
            if (k == 256) chk("wrap_cnt_0", 32'(fwd_cnt0), 32'd0);
        end
        tick(); #1;
        chk("wrap_done_push", 32'(d0_push), 32'h0);
        chk("wrap_cnt_after", 32'(fwd_cnt0), 32'd1);
        chk("wrap_idle", 32'(idle), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
